// File: rtl/neopixel_pkg.sv
// Shared definitions for the neopixel pattern generator: output-stage register
// addresses, FSM state encoding and the rainbow colour wheel.
package neopixel_pkg;

  localparam logic [31:0] ADDR_UPDATE = 32'h100;
  localparam logic [31:0] ADDR_STATUS = 32'h104;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2,
    POLL   = 2'd3
  } state_t;

  // Three-segment wheel: 0..84 red->green, 85..169 green->blue, 170..255 blue->red.
  function automatic logic [23:0] colour_wheel(input logic [7:0] w, input logic [2:0] shift);
    logic [7:0] k;
    logic [7:0] k3;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    if (w < 8'd85) begin
      k  = w;
      k3 = k + k + k;
      r  = 8'd255 - k3;
      g  = k3;
      b  = 8'd0;
    end else if (w < 8'd170) begin
      k  = w - 8'd85;
      k3 = k + k + k;
      r  = 8'd0;
      g  = 8'd255 - k3;
      b  = k3;
    end else begin
      k  = w - 8'd170;
      k3 = k + k + k;
      r  = k3;
      g  = 8'd0;
      b  = 8'd255 - k3;
    end
    return {g >> shift, r >> shift, b >> shift};
  endfunction

endpackage

// File: rtl/neopixel_frame_timer.sv
// Free-running frame-period counter; emits a registered one-cycle tick each
// time it wraps from PERIOD-1 back to 0.
module neopixel_frame_timer #(
  parameter int C_FREQ_HZ  = 125000000,
  parameter int C_FRAME_HZ = 30
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int          PERIOD = C_FREQ_HZ / C_FRAME_HZ;
  localparam logic [31:0] LAST   = 32'(PERIOD - 1);

  logic [31:0] cnt_q;
  logic        tick_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 32'd1;
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/neopixel_pattern_gen.sv
// Autonomous bus master that writes a rotating rainbow into the neopixel output
// stage once per frame. Define NEOPIXEL_POLL_TIMEOUT_EN to add a POLL timeout and poll_error.
module neopixel_pattern_gen
  import neopixel_pkg::*;
#(
  parameter int C_PIXELS       = 12,
  parameter int C_FREQ_HZ      = 125000000,
  parameter int C_FRAME_HZ     = 30,
  parameter int C_STEP         = 21,
  parameter int C_BRIGHT_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        clock_ctrl,
  output logic        reset_ctrl,
  output logic        write_readf,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic [15:0] frame_count,
  output logic        busy,
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
  output logic        poll_error,
`endif
  output state_t      dbg_state_o
);

  localparam logic [7:0] LAST_IDX = 8'(C_PIXELS - 1);
  localparam logic [7:0] STEP8    = 8'(C_STEP);
  localparam logic [2:0] SHIFT3   = 3'(C_BRIGHT_SHIFT);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] frame_q, frame_d;
  logic        armed_q, armed_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        rst_ctrl_q;
  logic        tick;
  logic [15:0] prod;
  logic [7:0]  pix_w;
  logic        unused_rd;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
  logic [23:0] to_q, to_d;
  logic        perr_q, perr_d;
`endif

  neopixel_frame_timer #(
    .C_FREQ_HZ (C_FREQ_HZ),
    .C_FRAME_HZ(C_FRAME_HZ)
  ) u_timer (
    .clk_i  (clock),
    .rst_n_i(reset),
    .tick_o (tick)
  );

  // Bus outputs are registered from the next state so a write is visible the
  // cycle after the tick, and addresses follow idx_d without a pipeline bubble.
  assign prod  = {8'd0, idx_d} * {8'd0, STEP8};
  assign pix_w = phase_q + prod[7:0];
  assign unused_rd = ^read_data[31:1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      frame_q <= '0;
      armed_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= ADDR_STATUS;
      wdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
      to_q    <= '0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
      to_q    <= to_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    rst_ctrl_q <= ~reset;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    frame_d = frame_q;
    armed_d = armed_q;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
    to_d    = to_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else idx_d = idx_q + 8'd1;
      end
      COMMIT: begin
        state_d = POLL;
        armed_d = 1'b0;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      POLL: begin
        // First POLL cycle only issues the read; read_data is valid from the second.
        armed_d = 1'b1;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
        to_d    = to_q + 24'd1;
`endif
        if (armed_q && !read_data[0]) begin
          state_d = IDLE;
          frame_d = frame_q + 16'd1;
          phase_d = phase_q + 8'd1;
        end
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
        else if (to_q == 24'hFF_FFFF) begin
          state_d = IDLE;
          perr_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d    = 1'b0;
    addr_d  = ADDR_STATUS;
    wdata_d = '0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      WRITE: begin
        wr_d    = 1'b1;
        addr_d  = {24'd0, idx_d};
        wdata_d = {8'h00, colour_wheel(pix_w, SHIFT3)};
      end
      COMMIT: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_UPDATE;
        wdata_d = 32'd1;
      end
      default: ;
    endcase
  end

  assign clock_ctrl  = clock;
  assign reset_ctrl  = rst_ctrl_q;
  assign write_readf = wr_q;
  assign address     = addr_q;
  assign write_data  = wdata_q;
  assign frame_count = frame_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
  assign poll_error  = perr_q;
`endif

endmodule

// File: tb/tb_neopixel_pattern_gen.sv
// Directed bench for neopixel_pattern_gen: 10-cycle frame period, 12 pixels,
// step 21, brightness shift 2, with a registered status-register responder.
module tb_neopixel_pattern_gen;
  import neopixel_pkg::*;

  logic        clock;
  logic        reset;
  logic        clock_ctrl;
  logic        reset_ctrl;
  logic        write_readf;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [15:0] frame_count;
  logic        busy;
  state_t      dbg_state;
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
  logic        poll_error;
`endif

  int checks = 0;
  int errors = 0;
  int commits = 0;
  int c0;
  int c1;
  int n;
  logic        status_busy;
  logic [31:0] cap [12];

  // Frame 0 pixel words, hand-computed from the wheel with w = 21*i, >>2.
  logic [31:0] exp_pix [12] = '{
    32'h00003F00, 32'h000F3000, 32'h001F2000, 32'h002F1000,
    32'h003F0000, 32'h0030000F, 32'h0021001E, 32'h0011002E,
    32'h0001003E, 32'h00000E31, 32'h00001E21, 32'h00002D12
  };

  neopixel_pattern_gen #(
    .C_PIXELS      (12),
    .C_FREQ_HZ     (1000),
    .C_FRAME_HZ    (100),
    .C_STEP        (21),
    .C_BRIGHT_SHIFT(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clock_ctrl (clock_ctrl),
    .reset_ctrl (reset_ctrl),
    .write_readf(write_readf),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .frame_count(frame_count),
    .busy       (busy),
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
    .poll_error (poll_error),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Status responder: one-cycle read latency.
  always @(posedge clock) read_data <= {31'd0, status_busy};

  // Bus monitor: capture pixel writes and count commits.
  always @(negedge clock) begin
    if (write_readf === 1'b1) begin
      if (address == ADDR_UPDATE) commits = commits + 1;
      else if (address < 32'd12) cap[address[3:0]] = write_data;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_wr"},    {31'd0, write_readf}, 32'd0);
    check32({tag, "_addr"},  address,              32'h104);
    check32({tag, "_wdata"}, write_data,           32'd0);
    check32({tag, "_fc"},    {16'd0, frame_count}, 32'd0);
    check32({tag, "_busy"},  {31'd0, busy},        32'd0);
    check32({tag, "_rctl"},  {31'd0, reset_ctrl},  32'd1);
    check32({tag, "_state"}, 32'(dbg_state),       32'(IDLE));
  endtask

  task automatic wait_frame(input logic [15:0] target, input int budget);
    int k;
    k = 0;
    while (frame_count !== target && k < budget) begin
      @(negedge clock);
      k++;
    end
    check32("frame_wait", {16'd0, frame_count}, {16'd0, target});
  endtask

  initial begin
    reset       = 1'b0;
    status_busy = 1'b0;

    // Reset state
    repeat (4) @(negedge clock);
    check_reset_vals("reset");
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
    check32("reset_perr", {31'd0, poll_error}, 32'd0);
`endif

    // First frame: tick after 10 cycles, first write on cycle 11
    reset = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check32("pre_write_wr", {31'd0, write_readf}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check32("f0_wr",    {31'd0, write_readf}, 32'd1);
      check32("f0_addr",  address,              32'(i));
      check32("f0_pixel", write_data,           exp_pix[i]);
    end
    @(negedge clock);
    check32("commit_wr",    {31'd0, write_readf}, 32'd1);
    check32("commit_addr",  address,              32'h100);
    check32("commit_wdata", write_data,           32'd1);
    @(negedge clock);
    check32("poll_wr",   {31'd0, write_readf}, 32'd0);
    check32("poll_addr", address,              32'h104);
    check32("poll_busy", {31'd0, busy},        32'd1);
    wait_frame(16'd1, 100);
    check32("f0_commits", commits, 32'd1);

    // Frame 1: phase advanced by one
    wait_frame(16'd2, 200);
    check32("f1_pix0", cap[0], 32'h00003F00);
    check32("f1_pix1", cap[1], 32'h00102F00);

    // Output stage stays busy: FSM parks in POLL, ticks dropped
    status_busy = 1'b1;
    c0 = commits;
    n = 0;
    while (dbg_state !== POLL && n < 200) begin
      @(negedge clock);
      n++;
    end
    check32("reach_poll", 32'(dbg_state), 32'(POLL));
    repeat (50) @(negedge clock);
    check32("hold_state",   32'(dbg_state),       32'(POLL));
    check32("hold_busy",    {31'd0, busy},        32'd1);
    check32("hold_fc",      {16'd0, frame_count}, 32'd2);
    check32("hold_commits", commits,              c0 + 1);
    status_busy = 1'b0;
    wait_frame(16'd3, 100);
    check32("f2_commits", commits, c0 + 1);
    check32("f2_pix1",    cap[1],  32'h00112E00);
    wait_frame(16'd4, 200);
    check32("f3_pix1",    cap[1],  32'h00122D00);
    check32("f3_commits", commits, c0 + 2);

    // Reset in the middle of WRITE at pixel 5
    n = 0;
    while (!(write_readf === 1'b1 && address == 32'd5) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check32("reach_pix5", address, 32'd5);
    c1 = commits;
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("midreset");
    repeat (3) @(negedge clock);
    check32("midreset_commits", commits, c1);
    reset = 1'b1;

    // 256 frames wrap the phase back to frame 0's colours
    wait_frame(16'd256, 20000);
    wait_frame(16'd257, 200);
    check32("wrap_pix0", cap[0], exp_pix[0]);
    check32("wrap_pix1", cap[1], exp_pix[1]);
`ifdef NEOPIXEL_POLL_TIMEOUT_EN
    check32("end_perr", {31'd0, poll_error}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neopixel_pattern_gen.md
Name: neopixel_pattern_gen

Overview:
- Autonomous upstream master for the neopixel output stage. Drives the same register control bus that the neopixel_driver master drives; used in place of that master.
- Once per frame period it computes a rotating rainbow, writes one GRB word per pixel, commits the frame, then polls until the output stage has finished shifting it out.
- Lets the board show a live pattern with no processor attached.

Parameters:
- C_PIXELS, 12, number of pixels written per frame (1..256).
- C_FREQ_HZ, 125000000, frequency of clock.
- C_FRAME_HZ, 30, frame update rate.
- C_STEP, 21, wheel offset between adjacent pixels (0..255).
- C_BRIGHT_SHIFT, 2, right shift applied to each colour byte (0..7).

Ports:
- clock  in  1  single system clock; also the control-bus clock.
- reset  in  1  synchronous, active-low reset.
- clock_ctrl  out  1  control-bus clock; equals clock.
- reset_ctrl  out  1  control-bus reset, active-high; registered ~reset.
- write_readf  out  1  1 = write, 0 = read; qualified by address.
- address  out  32  register address.
- write_data  out  32  write payload.
- read_data  in  32  read return; valid 1 cycle after a read address.
- frame_count  out  16  frames committed; wraps 0xFFFF -> 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Register map of the output stage:
  - 0..C_PIXELS-1: pixel words {8'h00,G,R,B}.
  - 32'h100 UPDATE: writing bit0 = 1 starts shift-out.
  - 32'h104 STATUS: bit0 = shift-out busy.
- Reset values, held while reset = 0: write_readf = 0, address = 32'h104, write_data = 0, frame_count = 0, busy = 0, phase = 0, state = IDLE, tick counter = 0, reset_ctrl = 1.
- Tick counter:
  - Counts 0..(C_FREQ_HZ/C_FRAME_HZ)-1 using integer division.
  - Pulses tick for 1 cycle on wrap.
  - A tick outside IDLE is dropped, never queued.
- Pixel colour: w = (phase + i*C_STEP) mod 256, computed in 8-bit wrap arithmetic.
  - w < 85: R = 255-3w, G = 3w, B = 0.
  - w < 170, with k = w-85: R = 0, G = 255-3k, B = 3k.
  - Otherwise, with k = w-170: R = 3k, G = 0, B = 255-3k.
  - Each byte is then >> C_BRIGHT_SHIFT.
- FSM (registered outputs):
  - IDLE: on tick, set i = 0 and go to WRITE.
  - WRITE: each cycle, write_readf = 1, address = i, write_data = colour(i), then i++. After i = C_PIXELS-1, go to COMMIT. Exactly C_PIXELS consecutive write cycles.
  - COMMIT: 1 cycle, write_readf = 1, address = 32'h100, write_data = 1. Then go to POLL.
  - POLL: write_readf = 0, address = 32'h104. Sample read_data[0] on the second and every later cycle in POLL, giving 1-cycle read latency. When the sample is 0, frame_count++, phase += 1 (mod 256), go to IDLE.
- write_readf returns to 0 in every cycle that is not a write.
- Frame latency: tick -> first write in 1 cycle. Minimum tick -> IDLE = C_PIXELS + 3 cycles.
- Reset mid-frame: the FSM aborts immediately; no partial commit is issued.
- C_PIXELS = 1: WRITE lasts exactly 1 cycle.

Optional Feature:
- Macro: NEOPIXEL_POLL_TIMEOUT_EN.
- When defined:
  - Adds output poll_error (1 bit, reset 0).
  - A 24-bit counter runs during POLL. When it reaches 2^24-1 the FSM goes to IDLE, sets poll_error sticky until reset, and skips the frame_count and phase advance.
- When undefined: POLL waits indefinitely and no poll_error port exists.

Decomposition:
- Package neopixel_pkg holds:
  - localparams ADDR_UPDATE = 32'h100 and ADDR_STATUS = 32'h104;
  - the FSM state encoding (IDLE, WRITE, COMMIT, POLL);
  - a function colour_wheel(w[7:0], shift) returning 24-bit {G,R,B}.
- One sub-module, neopixel_frame_timer: the tick counter with parameters C_FREQ_HZ and C_FRAME_HZ and a 1-cycle tick output.

Test Plan:
- Reset with C_FREQ_HZ = 1000, C_FRAME_HZ = 100 (period 10 cycles), status model returning 0 -> first write at address 0 on cycle 11 after reset release; 12 writes, then the commit, then frame_count = 1.
- Frame 0, C_STEP = 21, shift = 2 -> pixel 0 = 32'h00003F00 (G = 0, R = 63, B = 0); pixel 1 (w = 21): R = 48, G = 15, B = 0 -> 32'h000F3000.
- Status model holds busy = 1 for 50 cycles -> FSM stays in POLL, ticks in that window are dropped, exactly one commit per frame, phase advances by 1 only.
- Assert reset during WRITE at i = 5 -> next cycle all outputs at reset values, no write to 32'h100, frame_count unchanged.
- Run 256 frames -> phase wraps to 0 and pixel 0 colour repeats frame 0's value.
- With NEOPIXEL_POLL_TIMEOUT_EN, status stuck at 1 -> poll_error = 1 after 2^24 POLL cycles, FSM returns to IDLE, frame_count unchanged.
